// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and fixed-point helpers for fully connected layers
package fc_pkg;

   typedef enum logic [1:0] {
      FC_IDLE,
      FC_ACC,
      FC_EMIT
   } fc_bwd_state_t;

   localparam int SAT_W = 64;

   // Arithmetic right shift by frac_bits, then clamp to a signed width-bit range.
   function automatic logic signed [SAT_W-1:0] sat_shift(
      input logic signed [SAT_W-1:0] acc,
      input int                      width,
      input int                      frac_bits
   );
      logic signed [SAT_W-1:0] shifted;
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      shifted = acc >>> frac_bits;
      max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v   = -max_v - 64'sd1;
      if (shifted > max_v) begin
         return max_v;
      end
      if (shifted < min_v) begin
         return min_v;
      end
      return shifted;
   endfunction

endpackage

// File: rtl/mac_sat.sv
// rtl/mac_sat.sv - signed multiply-accumulate with clear/enable and saturated output
module mac_sat
   import fc_pkg::*;
#(
   parameter int PX_SIZE   = 8,
   parameter int ACC_W     = 18,
   parameter int FRAC_BITS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               en,
   input  logic [PX_SIZE-1:0] a,
   input  logic [PX_SIZE-1:0] b,
   output logic [PX_SIZE-1:0] sat_data
);

   logic signed [2*PX_SIZE-1:0] prod;
   logic signed [ACC_W-1:0]     acc_d;
   logic signed [ACC_W-1:0]     acc_q;
   logic signed [SAT_W-1:0]     sat_full;
   logic                        unused_hi;

   always_comb begin
      prod  = $signed(a) * $signed(b);
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + ACC_W'(prod);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   // The accumulator only moves outside EMIT, so this stays stable while stalled.
   assign sat_full  = sat_shift(SAT_W'(acc_q), PX_SIZE, FRAC_BITS);
   assign sat_data  = sat_full[PX_SIZE-1:0];
   assign unused_hi = ^sat_full[SAT_W-1:PX_SIZE];

endmodule

// File: rtl/fc_backward.sv
// rtl/fc_backward.sv - sequential input-gradient pass of a fully connected layer
module fc_backward
   import fc_pkg::*;
#(
   parameter int  INPUT_SIZE      = 5,
   parameter int  INPUT_CHANNELS  = 3,
   parameter int  OUTPUT_CHANNELS = 3,
   parameter int  PX_SIZE         = 8,
   parameter int  FRAC_BITS       = 4,
   localparam int FLAT_INPUT_SIZE = INPUT_SIZE * INPUT_SIZE * INPUT_CHANNELS,
   localparam int IDX_W           = $clog2(FLAT_INPUT_SIZE)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [OUTPUT_CHANNELS-1:0][INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] weights,
   input  logic [OUTPUT_CHANNELS-1:0][PX_SIZE-1:0] grad_out,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PX_SIZE-1:0]   out_data,
   output logic [IDX_W-1:0]     out_index,
   output logic                 done
);

   localparam int C_W   = (OUTPUT_CHANNELS > 1) ? $clog2(OUTPUT_CHANNELS) : 1;
   localparam int ACC_W = 2 * PX_SIZE + $clog2(OUTPUT_CHANNELS) + 1;
   localparam logic [C_W-1:0]   C_LAST = C_W'(OUTPUT_CHANNELS - 1);
   localparam logic [IDX_W-1:0] I_LAST = IDX_W'(FLAT_INPUT_SIZE - 1);

   fc_bwd_state_t                        state_q, state_d;
   logic [IDX_W-1:0]                     i_q, i_d;
   logic [C_W-1:0]                       c_q, c_d;
   logic [OUTPUT_CHANNELS-1:0][PX_SIZE-1:0] grad_q, grad_d;
   logic                                 done_q, done_d;
   logic                                 acc_clr, acc_en, hs;
   logic [FLAT_INPUT_SIZE*PX_SIZE-1:0]   w_row;
   logic [PX_SIZE-1:0]                   w_sel, g_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FC_IDLE;
         i_q     <= '0;
         c_q     <= '0;
         grad_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         c_q     <= c_d;
         grad_q  <= grad_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FC_IDLE: if (start) state_d = FC_ACC;
         FC_ACC:  if (c_q == C_LAST) state_d = FC_EMIT;
         FC_EMIT: if (hs) state_d = (i_q == I_LAST) ? FC_IDLE : FC_ACC;
         default: state_d = FC_IDLE;
      endcase
   end

   always_comb begin
      i_d    = i_q;
      c_d    = c_q;
      grad_d = grad_q;
      done_d = 1'b0;
      case (state_q)
         FC_IDLE: begin
            if (start) begin
               grad_d = grad_out;
               i_d    = '0;
               c_d    = '0;
            end
         end
         FC_ACC: begin
            if (c_q != C_LAST) c_d = c_q + 1'b1;
         end
         FC_EMIT: begin
            if (hs) begin
               c_d = '0;
               if (i_q == I_LAST) begin
                  i_d    = '0;
                  done_d = 1'b1;
               end else begin
                  i_d = i_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      out_valid = (state_q == FC_EMIT);
      busy      = (state_q != FC_IDLE);
      done      = done_q;
      out_index = i_q;
      hs        = out_valid && out_ready;
      acc_en    = (state_q == FC_ACC);
      acc_clr   = ((state_q == FC_IDLE) && start) ||
                  (hs && (i_q != I_LAST));
   end

   // Element i of a channel row sits at bits [i*PX_SIZE +: PX_SIZE] of the packed vector.
   assign w_row = weights[c_q];
   assign w_sel = w_row[int'(i_q)*PX_SIZE +: PX_SIZE];
   assign g_sel = grad_q[c_q];

   mac_sat #(
      .PX_SIZE  (PX_SIZE),
      .ACC_W    (ACC_W),
      .FRAC_BITS(FRAC_BITS)
   ) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (acc_clr),
      .en      (acc_en),
      .a       (w_sel),
      .b       (g_sel),
      .sat_data(out_data)
   );

endmodule

// File: tb/tb_fc_backward.sv
// tb/tb_fc_backward.sv - directed self-checking bench for fc_backward
module tb_fc_backward;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, out_ready;
   logic [63:0] weights;
   logic [15:0] grad_out;
   logic        busy, out_valid, done;
   logic [7:0]  out_data;
   logic [1:0]  out_index;

   logic        start1, ready1;
   logic [63:0] weights1;
   logic [15:0] grad_out1;
   logic        busy1, valid1, done1;
   logic [7:0]  data1;
   logic [1:0]  idx1;

   int vectors = 0;
   int miscompares = 0;
   int exp_v[4];

   always #5 clk = ~clk;

   fc_backward #(
      .INPUT_SIZE(2), .INPUT_CHANNELS(1), .OUTPUT_CHANNELS(2), .PX_SIZE(8), .FRAC_BITS(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .weights(weights), .grad_out(grad_out),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .done(done)
   );

   fc_backward #(
      .INPUT_SIZE(2), .INPUT_CHANNELS(1), .OUTPUT_CHANNELS(2), .PX_SIZE(8), .FRAC_BITS(4)
   ) dut_fx (
      .clk(clk), .rst_n(rst_n), .start(start1), .weights(weights1), .grad_out(grad_out1),
      .busy(busy1), .out_valid(valid1), .out_ready(ready1), .out_data(data1),
      .out_index(idx1), .done(done1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // Runs (or finishes) one pass on dut, checking values, order, stall stability and done.
   task automatic run0(input bit do_start, input int rdy_pct, input bit hold_start,
                       input bit mid_pulse, input bit chk_t, input string tag);
      int k, got, first_k, done_cnt;
      logic [7:0] pd;
      logic [1:0] pi;
      logic pv, pr;
      k = 0; got = 0; first_k = -1; done_cnt = 0;
      pv = 1'b0; pr = 1'b0; pd = '0; pi = '0;
      if (do_start) begin
         start = 1'b1;
         @(negedge clk);
         if (!hold_start) start = 1'b0;
      end
      while (k < 400 && done_cnt == 0) begin
         if (pv && !pr) begin
            check({tag, " stall valid"}, 32'(out_valid), 32'd1);
            check({tag, " stall data"}, 32'(out_data), 32'(pd));
            check({tag, " stall index"}, 32'(out_index), 32'(pi));
         end
         if (mid_pulse) start = (k == 5);
         if (out_valid && first_k < 0) first_k = k;
         if (done) begin
            done_cnt++;
            if (chk_t) check({tag, " done cycle"}, k, 12);
         end
         pv = out_valid; pd = out_data; pi = out_index;
         pr = ($urandom_range(99) < rdy_pct);
         out_ready = pr;
         if (out_valid && pr) begin
            if (got < 4) begin
               check({tag, " data"}, 32'($signed(out_data)), exp_v[got]);
               check({tag, " index"}, 32'(out_index), got);
            end
            got++;
         end
         @(negedge clk);
         k++;
      end
      check({tag, " elements"}, got, 4);
      check({tag, " done seen"}, done_cnt, 1);
      if (chk_t) check({tag, " first valid"}, first_k, 2);
      out_ready = 1'b0;
      if (mid_pulse) start = 1'b0;
   endtask

   initial begin
      int n, got1, dn1;
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
      start1 = 1'b0; ready1 = 1'b1;
      weights = '0; grad_out = '0; weights1 = '0; grad_out1 = '0;
      repeat (2) @(negedge clk);
      check("reset busy", 32'(busy), 0);
      check("reset valid", 32'(out_valid), 0);
      check("reset done", 32'(done), 0);
      check("reset index", 32'(out_index), 0);
      check("reset data", 32'(out_data), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic pass
      weights  = {8'd1, 8'd1, 8'd1, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1};
      grad_out = {8'd3, 8'd2};
      exp_v = '{5, 7, 9, 11};
      run0(1'b1, 100, 1'b0, 1'b0, 1'b1, "basic");
      @(negedge clk);
      check("basic done pulse", 32'(done), 0);
      check("basic idle", 32'(busy), 0);

      // Positive and negative saturation
      weights  = {8{8'd127}};
      grad_out = {8'd127, 8'd127};
      exp_v = '{127, 127, 127, 127};
      run0(1'b1, 100, 1'b0, 1'b0, 1'b0, "sat_pos");
      weights  = {{4{8'h80}}, {4{8'h7F}}};
      grad_out = {8'h7F, 8'h80};
      exp_v = '{-128, -128, -128, -128};
      run0(1'b1, 100, 1'b0, 1'b0, 1'b0, "sat_neg");

      // Backpressure at 30% ready
      weights  = {8'd1, 8'd1, 8'd1, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1};
      grad_out = {8'd3, 8'd2};
      exp_v = '{5, 7, 9, 11};
      run0(1'b1, 30, 1'b0, 1'b0, 1'b0, "bp");

      // Start held high: next pass accepted on the done cycle
      run0(1'b1, 100, 1'b1, 1'b0, 1'b1, "hold");
      @(negedge clk);
      check("hold restart busy", 32'(busy), 1);
      check("hold restart done", 32'(done), 0);
      start = 1'b0;
      run0(1'b0, 100, 1'b0, 1'b0, 1'b0, "hold2");

      // Start pulsed mid-pass is ignored
      run0(1'b1, 100, 1'b0, 1'b1, 1'b1, "midstart");
      @(negedge clk);
      check("midstart idle", 32'(busy), 0);

      // Asynchronous reset while index 2 is in EMIT
      out_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (n < 50 && !(out_valid && out_index == 2'd2)) begin
         @(negedge clk);
         n++;
      end
      check("reset reach idx2", 32'(out_index), 2);
      #2 rst_n = 1'b0;
      #1;
      check("async rst valid", 32'(out_valid), 0);
      check("async rst busy", 32'(busy), 0);
      check("async rst done", 32'(done), 0);
      check("async rst index", 32'(out_index), 0);
      check("async rst data", 32'(out_data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      run0(1'b1, 100, 1'b0, 1'b0, 1'b1, "post_rst");

      // Fixed point, FRAC_BITS=4: 1.0*0.5 + 1.0*(-1.5) = -1.0
      weights1  = {8{8'h10}};
      grad_out1 = {8'hE8, 8'h08};
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      got1 = 0; dn1 = 0; n = 0;
      while (n < 60 && dn1 == 0) begin
         if (valid1) begin
            check("fx data", 32'($signed(data1)), -16);
            check("fx index", 32'(idx1), got1);
            got1++;
         end
         if (done1) dn1++;
         @(negedge clk);
         n++;
      end
      check("fx elements", got1, 4);
      check("fx done", dn1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fc_backward.md
# fc_backward

Sequential backward (gradient) pass for the fully connected layer. Given the layer's weights and the output-gradient vector, it computes the input-gradient vector, one element per flattened input position. For each flat index i it computes the sum over c of `weights[c][i]*grad_out[c]`. It time-multiplexes a single multiply-accumulate unit and streams results out over a valid/ready handshake to the previous layer's backward stage.

## Interface
- `INPUT_SIZE`, 5: forward input width/height (square).
- `INPUT_CHANNELS`, 3: forward input channels.
- `OUTPUT_CHANNELS`, 3: forward output channels; the length of `grad_out`.
- `PX_SIZE`, 8: bits per value, signed two's complement.
- `FRAC_BITS`, 4: fractional bits in the fixed-point format; the product is right-shifted by this amount.
- `FLAT_INPUT_SIZE` (localparam): `INPUT_SIZE*INPUT_SIZE*INPUT_CHANNELS`.
- `clk`  in  1  sole clock. Everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new pass. Sampled only in IDLE.
- `weights`  in  `[OUTPUT_CHANNELS-1:0][INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0]`  same packing as the forward layer. Must be held stable while `busy`=1.
- `grad_out`  in  `[OUTPUT_CHANNELS-1:0][PX_SIZE-1:0]`  output gradient. Latched on start acceptance.
- `busy`  out  1  high from start acceptance until the pass completes.
- `out_valid`  out  1  `out_data` and `out_index` are valid.
- `out_ready`  in  1  the downstream stage accepts the output.
- `out_data`  out  `PX_SIZE`  saturated input-gradient element.
- `out_index`  out  `$clog2(FLAT_INPUT_SIZE)`  flat index i. Order is x, then y, then channel, matching the packed layout (i=0 is `[0][0][0]`).
- `done`  out  1  one-cycle pulse after the last element is accepted.

## Operation
- FSM states: IDLE, ACC, EMIT.
- **IDLE**: if `start`=1 then latch `grad_out`, set i=0, c=0, clear acc, set `busy`=1, go to ACC. Otherwise stay.
- **ACC**: acc += `weights[c][i]*grad_out_q[c]`; c++.
  - When c reaches `OUTPUT_CHANNELS-1`, the same edge performs the final add and goes to EMIT.
- **EMIT**: `out_valid`=1; `out_data` = sat(acc >>> `FRAC_BITS`); `out_index`=i.
  - On `out_valid && out_ready`, if i is the last index (`FLAT_INPUT_SIZE-1`): go to IDLE, `busy`→0, `done`=1 for the next cycle.
  - Otherwise: i++, c=0, clear acc, go to ACC.
- Arithmetic widths:
  - Each product is signed, 2*`PX_SIZE` bits.
  - The accumulator is 2*`PX_SIZE`+`$clog2(OUTPUT_CHANNELS)`+1 bits, so it never overflows.
  - The shift is arithmetic.
  - Saturation clamps to the range -2^(`PX_SIZE`-1) to 2^(`PX_SIZE`-1)-1.
- `start` is ignored while `busy`=1 (no queueing).
- `out_data` and `out_index` must stay stable while `out_valid`=1 and `out_ready`=0. `out_valid` never drops without a handshake.
- `done` and `start` in the same cycle: `done` pulses and the new start is accepted (state is IDLE at that edge).
- Reset, at any time including mid-pass: immediately IDLE.
  - `busy`=0, `out_valid`=0, `done`=0, `out_data`=0, `out_index`=0.
  - The accumulator, counters and latched gradient clear.
  - The partial pass is discarded.

## Timing
- Start accepted at edge T0. The first `out_valid` rises after edge T0+`OUTPUT_CHANNELS`.
- With `out_ready` held at 1, each element takes `OUTPUT_CHANNELS`+1 cycles.
- The last handshake occurs at edge T0+`FLAT_INPUT_SIZE`*(`OUTPUT_CHANNELS`+1). `done` is high in the cycle after it.
- Each cycle `out_ready`=0 during EMIT adds one cycle. No other stalls.
- All outputs are registered. No combinational path from `out_ready` or `start` to any output.

## Structure
- Shared package `fc_pkg`:
  - state enum `fc_bwd_state_t`.
  - `sat_shift` function (parameterised by width and `FRAC_BITS`), also reusable by future forward sequential layers.
- One sub-module, `mac_sat`: signed multiply, accumulate with clear/enable, shift-and-saturate output. The FSM and counters stay in `fc_backward`.

## Test plan
Default configuration for scenarios 1–3 and 5: `INPUT_SIZE`=2, `INPUT_CHANNELS`=1, `OUTPUT_CHANNELS`=2, `FRAC_BITS`=0 unless stated.
1. Basic pass:
   - Stimulus: weights c0={1,2,3,4}, c1={1,1,1,1}; `grad_out`={2,3}; `out_ready`=1.
   - Required: outputs 5,7,9,11 at indices 0–3; first `out_valid` 2 cycles after start; `done` 12 cycles after start.
2. Saturation:
   - Stimulus: all weights 127, `grad_out`={127,127}.
   - Required: every `out_data`=127.
   - Stimulus: c1 weights -128, `grad_out`={-128,127} with c0 weights 127.
   - Required: every `out_data`=-128.
3. Fixed point:
   - Stimulus: `FRAC_BITS`=4; weights 16 (1.0); `grad_out`={8,-24}.
   - Required: every `out_data`=-16.
4. Backpressure:
   - Stimulus: random `out_ready` at 30% duty with the scenario-1 stimulus.
   - Required: `out_data` and `out_index` stable while stalled; same 4 values in order; `done` once.
5. Start handling:
   - `start` held high throughout: a second pass is accepted exactly on the `done` cycle.
   - `start` pulsed mid-pass: ignored; the output sequence is unchanged.
6. Reset mid-pass:
   - Stimulus: deassert `rst_n` while at index 2 in EMIT.
   - Required: `out_valid`, `busy` and `done` all 0 immediately (asynchronous). After release, a fresh start reproduces scenario 1 exactly.
